// File: rtl/vram_data_port.sv
// Byte-addressed Wishbone window onto a 32-bit VRAM: auto-advancing pointer,
// byte write-through and a one-byte prefetch latch refilled after every move.
module vram_data_port #(
  parameter logic [3:0] RESET_INCR = 4'h1
) (
  input  logic        wb_clk_i,
  input  logic        wb_reset_i,
  input  logic        wb_strobe_i,
  input  logic        wb_write_i,
  input  logic [2:0]  wb_addr_i,
  input  logic [7:0]  wb_data_i,
  output logic [7:0]  wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic [14:0] vram_addr_o,
  output logic [31:0] vram_data_o,
  output logic [3:0]  vram_be_o,
  output logic        vram_we_o,
  output logic        vram_strobe_o,
  input  logic        vram_ack_i,
  input  logic [31:0] vram_data_i
);

  typedef enum logic [1:0] {IDLE, WRITE, FETCH} state_t;

  state_t      state_q;
  logic [16:0] ptr_q;
  logic [3:0]  inc_q;
  logic        dec_q;
  logic [7:0]  pf_q;
  logic        ack_q;
  logic [7:0]  rdata_q;
  logic [14:0] vaddr_q;
  logic [31:0] vdata_q;
  logic [3:0]  vbe_q;
  logic        vwe_q;
  logic        vstb_q;

  logic        accept;
  logic [16:0] step;
  logic [16:0] ptr_adv;
  logic [16:0] ptr_wr_d;
  logic [7:0]  rd_mux;
  logic [7:0]  lane_byte;
  logic [3:0]  lane_onehot;

  assign accept = wb_strobe_i && (state_q == IDLE);

  always_comb begin
    step = '0;
    if (inc_q != 4'd0) step = 17'(1) << (inc_q - 4'd1);
    ptr_adv = dec_q ? (ptr_q - step) : (ptr_q + step);
  end

  always_comb begin
    ptr_wr_d = ptr_q;
    case (wb_addr_i)
      3'd0:    ptr_wr_d[7:0]  = wb_data_i;
      3'd1:    ptr_wr_d[15:8] = wb_data_i;
      3'd2:    ptr_wr_d[16]   = wb_data_i[0];
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (wb_addr_i)
      3'd0:    rd_mux = ptr_q[7:0];
      3'd1:    rd_mux = ptr_q[15:8];
      3'd2:    rd_mux = {inc_q, dec_q, 2'b00, ptr_q[16]};
      3'd3:    rd_mux = pf_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    lane_byte   = vram_data_i[7:0];
    lane_onehot = 4'b0001;
    case (ptr_q[1:0])
      2'd0: begin lane_byte = vram_data_i[7:0];   lane_onehot = 4'b0001; end
      2'd1: begin lane_byte = vram_data_i[15:8];  lane_onehot = 4'b0010; end
      2'd2: begin lane_byte = vram_data_i[23:16]; lane_onehot = 4'b0100; end
      2'd3: begin lane_byte = vram_data_i[31:24]; lane_onehot = 4'b1000; end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      inc_q   <= RESET_INCR;
      dec_q   <= 1'b0;
      pf_q    <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
      vbe_q   <= '0;
      vwe_q   <= 1'b0;
      vstb_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ack_q   <= 1'b1;
            rdata_q <= rd_mux;
            if (wb_write_i && (wb_addr_i <= 3'd2)) begin
              ptr_q <= ptr_wr_d;
              if (wb_addr_i == 3'd2) begin
                inc_q <= wb_data_i[7:4];
                dec_q <= wb_data_i[3];
              end
              state_q <= FETCH;
              vstb_q  <= 1'b1;
              vwe_q   <= 1'b0;
              vbe_q   <= 4'hF;
              vaddr_q <= ptr_wr_d[16:2];
            end else if (wb_write_i && (wb_addr_i == 3'd3)) begin
              // The write target lives in the VRAM output registers, so ptr_q can advance now.
              ptr_q   <= ptr_adv;
              state_q <= WRITE;
              vstb_q  <= 1'b1;
              vwe_q   <= 1'b1;
              vbe_q   <= lane_onehot;
              vaddr_q <= ptr_q[16:2];
              vdata_q <= {4{wb_data_i}};
            end else if (!wb_write_i && (wb_addr_i == 3'd3)) begin
              ptr_q   <= ptr_adv;
              state_q <= FETCH;
              vstb_q  <= 1'b1;
              vwe_q   <= 1'b0;
              vbe_q   <= 4'hF;
              vaddr_q <= ptr_adv[16:2];
            end
          end
        end
        WRITE: begin
          if (vram_ack_i) begin
            state_q <= FETCH;
            vwe_q   <= 1'b0;
            vbe_q   <= 4'hF;
            vaddr_q <= ptr_q[16:2];
            vdata_q <= '0;
          end
        end
        FETCH: begin
          if (vram_ack_i) begin
            pf_q    <= lane_byte;
            state_q <= IDLE;
            vstb_q  <= 1'b0;
            vwe_q   <= 1'b0;
            vbe_q   <= '0;
            vaddr_q <= '0;
            vdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_stall_o    = (state_q != IDLE);
  assign wb_ack_o      = ack_q;
  assign wb_data_o     = rdata_q;
  assign vram_addr_o   = vaddr_q;
  assign vram_data_o   = vdata_q;
  assign vram_be_o     = vbe_q;
  assign vram_we_o     = vwe_q;
  assign vram_strobe_o = vstb_q;

endmodule

// File: tb/tb_vram_data_port.sv
// Bench for vram_data_port: directed vector table, hand-built corner sequences,
// then random accesses checked against a byte-array model of the pointer window.
module tb_vram_data_port;

  localparam logic [3:0] RI = 4'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_strobe = 1'b0, wb_write = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [7:0]  wb_wdata = '0;
  logic [7:0]  wb_rdata;
  logic        wb_ack, wb_stall;
  logic [14:0] vram_addr;
  logic [31:0] vram_wdata;
  logic [3:0]  vram_be;
  logic        vram_we, vram_strobe;
  logic        vram_ack = 1'b0;
  logic [31:0] vram_rdata = '0;

  vram_data_port #(.RESET_INCR(RI)) dut (
    .wb_clk_i(clk), .wb_reset_i(rst), .wb_strobe_i(wb_strobe), .wb_write_i(wb_write),
    .wb_addr_i(wb_addr), .wb_data_i(wb_wdata), .wb_data_o(wb_rdata), .wb_ack_o(wb_ack),
    .wb_stall_o(wb_stall), .vram_addr_o(vram_addr), .vram_data_o(vram_wdata),
    .vram_be_o(vram_be), .vram_we_o(vram_we), .vram_strobe_o(vram_strobe),
    .vram_ack_i(vram_ack), .vram_data_i(vram_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // VRAM contents as seen by the responder (words) and by the model (bytes)
  logic [31:0] vmem [32768];
  logic [7:0]  mmem [131072];
  int m_ptr, m_inc, m_dec, m_pf;

  bit resp_en = 1'b1;
  int lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_inc = int'(RI); m_dec = 0; m_pf = 0;
  endtask

  function automatic int m_advanced();
    int s = (m_inc == 0) ? 0 : (1 << (m_inc - 1));
    return (m_dec != 0 ? m_ptr - s : m_ptr + s) & 32'h1FFFF;
  endfunction

  task automatic m_apply(input bit we, input int addr, input int wd, output int exp_rd);
    case (addr)
      0: exp_rd = m_ptr & 255;
      1: exp_rd = (m_ptr >> 8) & 255;
      2: exp_rd = (m_inc << 4) | (m_dec << 3) | ((m_ptr >> 16) & 1);
      3: exp_rd = m_pf;
      default: exp_rd = 0;
    endcase
    if (we) begin
      case (addr)
        0: begin m_ptr = (m_ptr & 32'h1FF00) | wd; m_pf = int'(mmem[m_ptr]); end
        1: begin m_ptr = (m_ptr & 32'h100FF) | (wd << 8); m_pf = int'(mmem[m_ptr]); end
        2: begin
          m_inc = (wd >> 4) & 15; m_dec = (wd >> 3) & 1;
          m_ptr = (m_ptr & 32'h0FFFF) | ((wd & 1) << 16);
          m_pf = int'(mmem[m_ptr]);
        end
        3: begin mmem[m_ptr] = 8'(wd); m_ptr = m_advanced(); m_pf = int'(mmem[m_ptr]); end
        default: ;
      endcase
    end else if (addr == 3) begin
      m_ptr = m_advanced(); m_pf = int'(mmem[m_ptr]);
    end
  endtask

  // VRAM responder: random latency, single-cycle ack, honours byte enables
  initial forever begin
    @(negedge clk);
    if (resp_en) begin
      if (vram_ack) begin
        vram_ack = 1'b0;
        lat = $urandom_range(0, 3);
      end else if (vram_strobe) begin
        if (lat == 0) begin
          vram_ack = 1'b1;
          if (vram_we) begin
            for (int k = 0; k < 4; k++)
              if (vram_be[k]) vmem[vram_addr][8*k +: 8] = vram_wdata[8*k +: 8];
          end else begin
            vram_rdata = vmem[vram_addr];
          end
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic wb_access(input bit we, input logic [2:0] addr, input logic [7:0] wd,
                           output logic [7:0] rd);
    bit got = 1'b0;
    rd = '0;
    @(negedge clk);
    wb_strobe = 1'b1; wb_write = we; wb_addr = addr; wb_wdata = wd;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (wb_ack) begin rd = wb_rdata; got = 1'b1; end
    end
    wb_strobe = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input bit we, input logic [2:0] addr, input logic [7:0] wd,
                       input bit use_tbl, input logic [7:0] tbl_exp, input string name);
    int mexp;
    logic [7:0] rd;
    m_apply(we, int'(addr), int'(wd), mexp);
    wb_access(we, addr, wd, rd);
    if (!we) begin
      if (use_tbl) check(name, {24'h0, rd}, {24'h0, tbl_exp});
      else         check(name, {24'h0, rd}, mexp[31:0] & 32'hFF);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!wb_stall) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    bit         we;
    logic [2:0] addr;
    logic [7:0] wd;
    bit         chk;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int dummy;
    logic [14:0] hold_addr;
    logic [7:0]  rd;

    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] hold_addr;
    int mexp;
    logic [31:0] w;

    for (int i = 0; i < 32768; i++) begin
      w = (i == 1) ? 32'hAABBCCDD : $urandom;
      vmem[i] = w;
      for (int k = 0; k < 4; k++) mmem[4*i + k] = w[8*k +: 8];
    end
    m_reset();

    // reset state, then REQ-style walk-throughs of pointer arithmetic
    tbl.push_back('{0, 3'd2, 8'h00, 1, 8'h10});
    tbl.push_back('{0, 3'd3, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h01});
    tbl.push_back('{1, 3'd2, 8'h10, 0, 8'h00});
    tbl.push_back('{1, 3'd1, 8'h00, 0, 8'h00});
    tbl.push_back('{1, 3'd0, 8'h05, 0, 8'h00});
    tbl.push_back('{0, 3'd3, 8'h00, 1, 8'hCC});
    tbl.push_back('{0, 3'd3, 8'h00, 1, 8'hBB});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h07});
    tbl.push_back('{1, 3'd0, 8'h02, 0, 8'h00});
    tbl.push_back('{1, 3'd3, 8'h5A, 0, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h03});
    tbl.push_back('{1, 3'd0, 8'h02, 0, 8'h00});
    tbl.push_back('{0, 3'd3, 8'h00, 1, 8'h5A});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h03});
    tbl.push_back('{1, 3'd2, 8'h11, 0, 8'h00});
    tbl.push_back('{1, 3'd1, 8'hFF, 0, 8'h00});
    tbl.push_back('{1, 3'd0, 8'hFF, 0, 8'h00});
    tbl.push_back('{0, 3'd3, 8'h00, 0, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 3'd1, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 3'd2, 8'h00, 1, 8'h10});
    tbl.push_back('{1, 3'd2, 8'h18, 0, 8'h00});
    tbl.push_back('{0, 3'd3, 8'h00, 0, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'hFF});
    tbl.push_back('{0, 3'd1, 8'h00, 1, 8'hFF});
    tbl.push_back('{0, 3'd2, 8'h00, 1, 8'h19});
    tbl.push_back('{1, 3'd2, 8'hF1, 0, 8'h00});
    tbl.push_back('{1, 3'd1, 8'hC0, 0, 8'h00});
    tbl.push_back('{1, 3'd0, 8'h00, 0, 8'h00});
    tbl.push_back('{0, 3'd3, 8'h00, 0, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 3'd1, 8'h00, 1, 8'h00});
    tbl.push_back('{0, 3'd2, 8'h00, 1, 8'hF0});
    tbl.push_back('{0, 3'd5, 8'h00, 1, 8'h00});
    tbl.push_back('{1, 3'd6, 8'hAA, 0, 8'h00});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 8'h00});

    repeat (3) @(negedge clk);
    check("rst_ack", {31'h0, wb_ack}, 32'd0);
    check("rst_rdata", {24'h0, wb_rdata}, 32'd0);
    check("rst_vram", {vram_strobe, vram_we, vram_be, vram_addr, vram_wdata == 32'h0},
          {1'b0, 1'b0, 4'h0, 15'h0, 1'b1});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_fetch", {31'h0, vram_strobe}, 32'd0);

    foreach (tbl[i])
      do_op(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].chk, tbl[i].exp,
            $sformatf("tbl[%0d]", i));
    wait_idle();

    // WRITE request shape: PTR=2, DATA=0x5A
    do_op(1, 3'd2, 8'h10, 0, 8'h00, "set_inc");
    do_op(1, 3'd1, 8'h00, 0, 8'h00, "set_p1");
    do_op(1, 3'd0, 8'h02, 0, 8'h00, "set_p0");
    wait_idle();
    resp_en = 1'b0;
    m_apply(1, 3, 8'h5A, mexp);
    @(negedge clk);
    wb_strobe = 1'b1; wb_write = 1'b1; wb_addr = 3'd3; wb_wdata = 8'h5A;
    @(negedge clk);
    wb_strobe = 1'b0;
    check("wr_ack", {31'h0, wb_ack}, 32'd1);
    check("wr_req", {vram_strobe, vram_we, vram_be, vram_addr}, {1'b1, 1'b1, 4'b0100, 15'h0});
    check("wr_data", vram_wdata, 32'h5A5A5A5A);
    lat = 0; resp_en = 1'b1;
    wait_idle();
    do_op(0, 3'd0, 8'h00, 1, 8'h03, "wr_ptr_after");

    // long FETCH with strobe held: stall stays up, request stable
    wait_idle();
    resp_en = 1'b0;
    m_apply(0, 3, 0, mexp);
    @(negedge clk);
    wb_strobe = 1'b1; wb_write = 1'b0; wb_addr = 3'd3;
    @(negedge clk);
    check("fetch_rd_ack", {31'h0, wb_ack}, 32'd1);
    check("fetch_rd_data", {24'h0, wb_rdata}, mexp[31:0] & 32'hFF);
    wb_addr = 3'd0;
    hold_addr = vram_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_sig", {wb_stall, wb_ack, vram_strobe, vram_we, vram_be, vram_addr},
            {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, hold_addr});
    end
    vram_rdata = vmem[vram_addr]; vram_ack = 1'b1;
    @(negedge clk);
    vram_ack = 1'b0;
    check("stall_release", {31'h0, wb_stall}, 32'd0);
    m_apply(0, 0, 0, mexp);
    @(negedge clk);
    wb_strobe = 1'b0;
    check("after_stall_ack", {23'h0, wb_ack, wb_rdata}, {23'h0, 1'b1, mexp[7:0]});

    // reset in the middle of a WRITE, then a stray ack
    @(negedge clk);
    wb_strobe = 1'b1; wb_write = 1'b1; wb_addr = 3'd3; wb_wdata = 8'hE7;
    @(negedge clk);
    wb_strobe = 1'b0;
    check("pre_rst_strobe", {31'h0, vram_strobe}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst", {vram_strobe, vram_we, wb_ack, wb_stall}, 4'b0000);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    vram_rdata = $urandom; vram_ack = 1'b1;
    @(negedge clk);
    vram_ack = 1'b0;
    @(negedge clk);
    check("stray_ack", {30'h0, vram_strobe, wb_stall}, 32'd0);
    lat = 0; resp_en = 1'b1;
    do_op(0, 3'd2, 8'h00, 1, {RI, 4'b0000}, "rst_reg2");
    do_op(0, 3'd0, 8'h00, 1, 8'h00, "rst_reg0");
    do_op(0, 3'd3, 8'h00, 1, 8'h00, "rst_pf");
    wait_idle();

    // unmapped read and back-to-back register reads
    @(negedge clk);
    wb_strobe = 1'b1; wb_write = 1'b0; wb_addr = 3'd5;
    @(negedge clk);
    wb_addr = 3'd0;
    check("reg5", {21'h0, wb_ack, wb_stall, vram_strobe, wb_rdata}, {21'h0, 3'b100, 8'h00});
    m_apply(0, 0, 0, mexp);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b", {22'h0, wb_ack, wb_stall, wb_rdata}, {22'h0, 2'b10, mexp[7:0]});
    end
    wb_strobe = 1'b0;

    // randomized accesses against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      bit we;
      a  = ($urandom_range(0, 9) < 4) ? 3'd3 : 3'($urandom_range(0, 7));
      we = 1'($urandom);
      do_op(we, a, 8'($urandom), 0, 8'h00, $sformatf("rnd[%0d] a%0d", i, a));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
